// File: rtl/instruction_decode_if.sv
// -----------------------------------------------------------------------------
// instruction_decode_if
// Bundle of the signals between the fetch stage, the writeback path and the
// execute stage around the decode stage.
//   master : drives fetch payload (ce/instr/pc), stall/flush and writeback;
//            observes the decoded payload and ready.
//   slave  : the decode stage itself.
// Inputs to decode:  d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_flush,
//                    d_i_wb_we, d_i_wb_addr, d_i_wb_data
// Outputs of decode: d_o_ready, d_o_ce, d_o_pc, d_o_opcode, d_o_funct,
//                    d_o_shamt, d_o_rs_addr, d_o_rt_addr, d_o_rd_addr,
//                    d_o_rs_data, d_o_rt_data, d_o_imm, d_o_jaddr,
//                    d_o_reg_write, d_o_illegal
// -----------------------------------------------------------------------------
interface instruction_decode_if #(
    parameter int PC_WIDTH = 32,
    parameter int IWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5
);
    logic                d_i_ce;
    logic [IWIDTH-1:0]   d_i_instr;
    logic [PC_WIDTH-1:0] d_i_pc;
    logic                d_i_stall;
    logic                d_i_flush;
    logic                d_i_wb_we;
    logic [AWIDTH-1:0]   d_i_wb_addr;
    logic [DWIDTH-1:0]   d_i_wb_data;

    logic                d_o_ready;
    logic                d_o_ce;
    logic [PC_WIDTH-1:0] d_o_pc;
    logic [5:0]          d_o_opcode;
    logic [5:0]          d_o_funct;
    logic [4:0]          d_o_shamt;
    logic [AWIDTH-1:0]   d_o_rs_addr;
    logic [AWIDTH-1:0]   d_o_rt_addr;
    logic [AWIDTH-1:0]   d_o_rd_addr;
    logic [DWIDTH-1:0]   d_o_rs_data;
    logic [DWIDTH-1:0]   d_o_rt_data;
    logic [DWIDTH-1:0]   d_o_imm;
    logic [25:0]         d_o_jaddr;
    logic                d_o_reg_write;
    logic                d_o_illegal;

    modport master (
        output d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_flush,
               d_i_wb_we, d_i_wb_addr, d_i_wb_data,
        input  d_o_ready, d_o_ce, d_o_pc, d_o_opcode, d_o_funct, d_o_shamt,
               d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_rs_data,
               d_o_rt_data, d_o_imm, d_o_jaddr, d_o_reg_write, d_o_illegal
    );

    modport slave (
        input  d_i_ce, d_i_instr, d_i_pc, d_i_stall, d_i_flush,
               d_i_wb_we, d_i_wb_addr, d_i_wb_data,
        output d_o_ready, d_o_ce, d_o_pc, d_o_opcode, d_o_funct, d_o_shamt,
               d_o_rs_addr, d_o_rt_addr, d_o_rd_addr, d_o_rs_data,
               d_o_rt_data, d_o_imm, d_o_jaddr, d_o_reg_write, d_o_illegal
    );
endinterface

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// MIPS decode stage. Captures the fetched instruction, cracks R/I/J fields,
// reads two operands from a 32x32 register file (with same-edge writeback
// bypass), resolves immediate/destination/control flags and presents the
// result as a registered payload one cycle later.
// Ports:
//   d_clk  : clock, rising edge
//   d_rst  : asynchronous active-low reset (clears payload and register file)
//   bus    : instruction_decode_if.slave (fetch in, writeback in, payload out)
// -----------------------------------------------------------------------------
module instruction_decode #(
    parameter int PC_WIDTH = 32,
    parameter int IWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5
) (
    input  logic                  d_clk,
    input  logic                  d_rst,
    instruction_decode_if.slave   bus
);
    localparam int NREG = 1 << AWIDTH;

    logic [DWIDTH-1:0]   r_regs [NREG];

    logic                r_ce_p1;
    logic [PC_WIDTH-1:0] r_pc_p1;
    logic [5:0]          r_opcode_p1;
    logic [5:0]          r_funct_p1;
    logic [4:0]          r_shamt_p1;
    logic [AWIDTH-1:0]   r_rs_addr_p1;
    logic [AWIDTH-1:0]   r_rt_addr_p1;
    logic [AWIDTH-1:0]   r_rd_addr_p1;
    logic [DWIDTH-1:0]   r_rs_data_p1;
    logic [DWIDTH-1:0]   r_rt_data_p1;
    logic [DWIDTH-1:0]   r_imm_p1;
    logic [25:0]         r_jaddr_p1;
    logic                r_reg_write_p1;
    logic                r_illegal_p1;

    logic [IWIDTH-1:0]   w_instr;
    logic [5:0]          w_opcode;
    logic [5:0]          w_funct;
    logic [AWIDTH-1:0]   w_rs;
    logic [AWIDTH-1:0]   w_rt;
    logic [AWIDTH-1:0]   w_rd_field;
    logic [AWIDTH-1:0]   w_dest;
    logic [DWIDTH-1:0]   w_rs_data;
    logic [DWIDTH-1:0]   w_rt_data;
    logic [DWIDTH-1:0]   w_imm;
    logic                w_writes;
    logic                w_supported;

    // Register 0 reads as zero; a writeback to the same register at this edge
    // is forwarded so the captured operand is the value being written.
    function automatic logic [DWIDTH-1:0] read_reg(
        input logic [AWIDTH-1:0] addr,
        input logic [DWIDTH-1:0] stored,
        input logic              wb_we,
        input logic [AWIDTH-1:0] wb_addr,
        input logic [DWIDTH-1:0] wb_data
    );
        if (addr == '0)                   return '0;
        else if (wb_we && wb_addr == addr) return wb_data;
        else                              return stored;
    endfunction

    assign w_instr    = bus.d_i_instr;
    assign w_opcode   = w_instr[31:26];
    assign w_funct    = w_instr[5:0];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd_field = w_instr[15:11];

    assign w_rs_data = read_reg(w_rs, r_regs[w_rs], bus.d_i_wb_we,
                                bus.d_i_wb_addr, bus.d_i_wb_data);
    assign w_rt_data = read_reg(w_rt, r_regs[w_rt], bus.d_i_wb_we,
                                bus.d_i_wb_addr, bus.d_i_wb_data);

    always_comb begin
        w_imm       = {{(DWIDTH-16){w_instr[15]}}, w_instr[15:0]};
        w_dest      = w_rt;
        w_writes    = 1'b0;
        w_supported = 1'b0;
        unique case (w_opcode)
            6'h0C, 6'h0D, 6'h0E: w_imm = {{(DWIDTH-16){1'b0}}, w_instr[15:0]};
            6'h0F:               w_imm = {w_instr[15:0], {(DWIDTH-16){1'b0}}};
            default: ;
        endcase
        if (w_opcode == 6'h00)      w_dest = w_rd_field;
        else if (w_opcode == 6'h03) w_dest = AWIDTH'(31);
        case (w_opcode)
            6'h00:                          w_writes = (w_funct != 6'h08);
            6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_writes = 1'b1;
            default:                        w_writes = 1'b0;
        endcase
        case (w_opcode)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: w_supported = 1'b1;
            default:             w_supported = 1'b0;
        endcase
    end

    // Register file: writes happen regardless of stall/flush.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (bus.d_i_wb_we && bus.d_i_wb_addr != '0) begin
            r_regs[bus.d_i_wb_addr] <= bus.d_i_wb_data;
        end
    end

    // ---- stage p1: decoded payload register --------------------------------
    // Flush beats stall; an idle or flushed slot presents an all-zero payload.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst || bus.d_i_flush || (!bus.d_i_stall && !bus.d_i_ce)) begin
            r_ce_p1        <= 1'b0;
            r_pc_p1        <= '0;
            r_opcode_p1    <= '0;
            r_funct_p1     <= '0;
            r_shamt_p1     <= '0;
            r_rs_addr_p1   <= '0;
            r_rt_addr_p1   <= '0;
            r_rd_addr_p1   <= '0;
            r_rs_data_p1   <= '0;
            r_rt_data_p1   <= '0;
            r_imm_p1       <= '0;
            r_jaddr_p1     <= '0;
            r_reg_write_p1 <= 1'b0;
            r_illegal_p1   <= 1'b0;
        end else if (!bus.d_i_stall) begin
            r_ce_p1        <= 1'b1;
            r_pc_p1        <= bus.d_i_pc;
            r_opcode_p1    <= w_opcode;
            r_funct_p1     <= w_funct;
            r_shamt_p1     <= w_instr[10:6];
            r_rs_addr_p1   <= w_rs;
            r_rt_addr_p1   <= w_rt;
            r_rd_addr_p1   <= w_dest;
            r_rs_data_p1   <= w_rs_data;
            r_rt_data_p1   <= w_rt_data;
            r_imm_p1       <= w_imm;
            r_jaddr_p1     <= w_instr[25:0];
            r_reg_write_p1 <= w_writes && w_supported && (w_dest != '0);
            r_illegal_p1   <= !w_supported;
        end
    end

    assign bus.d_o_ready     = ~bus.d_i_stall;
    assign bus.d_o_ce        = r_ce_p1;
    assign bus.d_o_pc        = r_pc_p1;
    assign bus.d_o_opcode    = r_opcode_p1;
    assign bus.d_o_funct     = r_funct_p1;
    assign bus.d_o_shamt     = r_shamt_p1;
    assign bus.d_o_rs_addr   = r_rs_addr_p1;
    assign bus.d_o_rt_addr   = r_rt_addr_p1;
    assign bus.d_o_rd_addr   = r_rd_addr_p1;
    assign bus.d_o_rs_data   = r_rs_data_p1;
    assign bus.d_o_rt_data   = r_rt_data_p1;
    assign bus.d_o_imm       = r_imm_p1;
    assign bus.d_o_jaddr     = r_jaddr_p1;
    assign bus.d_o_reg_write = r_reg_write_p1;
    assign bus.d_o_illegal   = r_illegal_p1;
endmodule

// File: tb/tb_instruction_decode.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode
// Directed bench for instruction_decode: reset state, writeback/bypass,
// immediate and destination resolution, illegal opcodes, stall/flush, idle
// slots and an asynchronous reset pulse mid-stream.
// -----------------------------------------------------------------------------
module tb_instruction_decode;
    logic d_clk;
    logic d_rst;
    int   n_pass;
    int   n_total;

    instruction_decode_if #(.PC_WIDTH(32), .IWIDTH(32), .DWIDTH(32), .AWIDTH(5)) bus ();

    instruction_decode #(.PC_WIDTH(32), .IWIDTH(32), .DWIDTH(32), .AWIDTH(5)) dut (
        .d_clk (d_clk),
        .d_rst (d_rst),
        .bus   (bus.slave)
    );

    initial begin
        d_clk = 1'b0;
        forever #5 d_clk = ~d_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge d_clk);
        #1;
    endtask

    task automatic present(input logic ce, input logic [31:0] instr, input logic [31:0] pc);
        bus.d_i_ce    = ce;
        bus.d_i_instr = instr;
        bus.d_i_pc    = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        bus.d_i_wb_we   = we;
        bus.d_i_wb_addr = addr;
        bus.d_i_wb_data = data;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        d_rst   = 1'b0;
        present(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        bus.d_i_stall = 1'b0;
        bus.d_i_flush = 1'b0;

        // Reset state
        #12;
        chk("rst_ce",    bus.d_o_ce, 0);
        chk("rst_pc",    bus.d_o_pc, 0);
        chk("rst_rs",    bus.d_o_rs_data, 0);
        chk("rst_ready", bus.d_o_ready, 1);
        d_rst = 1'b1;

        // Write r5 = 0x1234, then ADD r3,r5,r5
        wb(1'b1, 5'd5, 32'h0000_1234);
        step();
        wb(1'b0, 5'd0, 32'h0);
        present(1'b1, 32'h00A5_1820, 32'h0000_0100);
        step();
        chk("add_ce",     bus.d_o_ce, 1);
        chk("add_pc",     bus.d_o_pc, 32'h100);
        chk("add_rs",     bus.d_o_rs_data, 32'h1234);
        chk("add_rt",     bus.d_o_rt_data, 32'h1234);
        chk("add_rd",     bus.d_o_rd_addr, 3);
        chk("add_rw",     bus.d_o_reg_write, 1);
        chk("add_funct",  bus.d_o_funct, 6'h20);
        chk("add_rsaddr", bus.d_o_rs_addr, 5);

        // Same-edge bypass: r7 = DEADBEEF while decoding ORI r2,r7,0x8001
        wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        present(1'b1, 32'h34E2_8001, 32'h0000_0104);
        step();
        chk("ori_rs",  bus.d_o_rs_data, 32'hDEAD_BEEF);
        chk("ori_imm", bus.d_o_imm, 32'h0000_8001);
        chk("ori_rd",  bus.d_o_rd_addr, 2);
        chk("ori_op",  bus.d_o_opcode, 6'h0D);

        // ADDI r4,r0,-1 while writing 0x55 to r0
        wb(1'b1, 5'd0, 32'h0000_0055);
        present(1'b1, 32'h2004_FFFF, 32'h0000_0108);
        step();
        chk("addi_imm", bus.d_o_imm, 32'hFFFF_FFFF);
        chk("addi_rs",  bus.d_o_rs_data, 0);
        chk("addi_rd",  bus.d_o_rd_addr, 4);
        chk("addi_rw",  bus.d_o_reg_write, 1);

        // ADD r3,r7,r0: r7 stored from bypass edge, r0 still zero
        wb(1'b0, 5'd0, 32'h0);
        present(1'b1, 32'h00E0_1820, 32'h0000_010C);
        step();
        chk("r7_stored", bus.d_o_rs_data, 32'hDEAD_BEEF);
        chk("r0_zero",   bus.d_o_rt_data, 0);

        // JAL
        present(1'b1, 32'h0C10_0000, 32'h0000_0110);
        step();
        chk("jal_rd",    bus.d_o_rd_addr, 31);
        chk("jal_rw",    bus.d_o_reg_write, 1);
        chk("jal_jaddr", bus.d_o_jaddr, 32'h0010_0000);

        // SW r3,4(r5)
        present(1'b1, 32'hACA3_0004, 32'h0000_0114);
        step();
        chk("sw_rw",  bus.d_o_reg_write, 0);
        chk("sw_ill", bus.d_o_illegal, 0);
        chk("sw_imm", bus.d_o_imm, 32'h4);
        chk("sw_rs",  bus.d_o_rs_data, 32'h1234);

        // Unsupported opcode 0x3F
        present(1'b1, 32'hFC22_1234, 32'h0000_0118);
        step();
        chk("ill_ill", bus.d_o_illegal, 1);
        chk("ill_rw",  bus.d_o_reg_write, 0);
        chk("ill_ce",  bus.d_o_ce, 1);
        chk("ill_op",  bus.d_o_opcode, 6'h3F);

        // LUI r15,0xABCD
        present(1'b1, 32'h3C0F_ABCD, 32'h0000_011C);
        step();
        chk("lui_imm", bus.d_o_imm, 32'hABCD_0000);
        chk("lui_rd",  bus.d_o_rd_addr, 15);

        // JR r31 with nonzero rd field: no register write
        present(1'b1, 32'h03E0_0808, 32'h0000_0120);
        step();
        chk("jr_rw", bus.d_o_reg_write, 0);

        // ADD with rd = 0: write suppressed
        present(1'b1, 32'h00A5_0020, 32'h0000_0124);
        step();
        chk("rd0_rw", bus.d_o_reg_write, 0);

        // Stall for three cycles mid-stream
        present(1'b1, 32'h00A5_1820, 32'h0000_0200);
        step();
        chk("pre_stall_pc", bus.d_o_pc, 32'h200);
        bus.d_i_stall = 1'b1;
        present(1'b1, 32'h2004_FFFF, 32'h0000_0204);
        #1;
        chk("stall_ready", bus.d_o_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.d_o_pc, 32'h200);
            chk("stall_op", bus.d_o_rd_addr, 3);
            chk("stall_ce", bus.d_o_ce, 1);
        end

        // Flush together with stall
        bus.d_i_flush = 1'b1;
        step();
        chk("flush_ce", bus.d_o_ce, 0);
        chk("flush_pc", bus.d_o_pc, 0);
        chk("flush_rs", bus.d_o_rs_data, 0);
        chk("flush_rd", bus.d_o_rd_addr, 0);
        bus.d_i_flush = 1'b0;
        bus.d_i_stall = 1'b0;

        // Valid, idle, valid
        present(1'b1, 32'h00A5_1820, 32'h0000_0300);
        step();
        chk("ce_a", bus.d_o_ce, 1);
        present(1'b0, 32'h00A5_1820, 32'h0000_0304);
        step();
        chk("ce_b",    bus.d_o_ce, 0);
        chk("ce_b_pc", bus.d_o_pc, 0);
        present(1'b1, 32'h00A5_1820, 32'h0000_0308);
        step();
        chk("ce_c",    bus.d_o_ce, 1);
        chk("ce_c_pc", bus.d_o_pc, 32'h308);

        // Asynchronous reset pulse mid-cycle
        #1;
        d_rst = 1'b0;
        #1;
        chk("arst_ce", bus.d_o_ce, 0);
        chk("arst_rs", bus.d_o_rs_data, 0);
        present(1'b1, 32'h00E7_1820, 32'h0000_0400);
        #1;
        d_rst = 1'b1;
        step();
        chk("post_rst_ce", bus.d_o_ce, 1);
        chk("post_rst_r7", bus.d_o_rs_data, 0);
        present(1'b1, 32'h00A5_1820, 32'h0000_0404);
        step();
        chk("post_rst_r5", bus.d_o_rt_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second stage of the MIPS pipeline, directly downstream of the fetch stage. Captures the fetch stage's instruction, PC and valid strobe and holds a 32×32 register file with a writeback port. Cracks R/I/J-format fields, reads operands with same-cycle write bypass, and computes the extended immediate, destination register and control flags. Presents everything one cycle later as a registered payload for the execute stage.

## Interface
- PC_WIDTH, 32, PC width
- IWIDTH, 32, instruction width
- DWIDTH, 32, register/data width
- AWIDTH, 5, register address width (2^AWIDTH registers)

- d_clk  in  1  clock, rising edge
- d_rst  in  1  reset, asynchronous, active-low
- d_i_ce  in  1  fetch valid (fetch f_o_ce)
- d_i_instr  in  IWIDTH  instruction (fetch f_o_instr)
- d_i_pc  in  PC_WIDTH  PC (fetch f_o_pc)
- d_i_stall  in  1  downstream stall; hold outputs
- d_i_flush  in  1  kill in-flight and incoming instruction
- d_i_wb_we  in  1  writeback enable
- d_i_wb_addr  in  AWIDTH  writeback register
- d_i_wb_data  in  DWIDTH  writeback data
- d_o_ready  out  1  combinational, = ~d_i_stall
- d_o_ce  out  1  payload valid
- d_o_pc  out  PC_WIDTH  PC of decoded instruction
- d_o_opcode  out  6  instr[31:26]
- d_o_funct  out  6  instr[5:0]
- d_o_shamt  out  5  instr[10:6]
- d_o_rs_addr, d_o_rt_addr  out  AWIDTH  instr[25:21], instr[20:16]
- d_o_rd_addr  out  AWIDTH  resolved destination
- d_o_rs_data, d_o_rt_data  out  DWIDTH  operand values
- d_o_imm  out  DWIDTH  extended immediate
- d_o_jaddr  out  26  instr[25:0]
- d_o_reg_write  out  1  instruction writes a register
- d_o_illegal  out  1  unsupported opcode

## Operation
- Register file: 2^AWIDTH × DWIDTH. All entries clear on reset. Written at the d_clk edge when d_i_wb_we=1 and d_i_wb_addr≠0. Register 0 always reads 0. Writes occur regardless of stall or flush.
- Read bypass: if d_i_wb_we=1 and d_i_wb_addr equals rs (or rt) and is ≠0, the captured operand is d_i_wb_data, not the stored value.
- Capture rule at each edge, in priority order:
  - d_i_flush=1: d_o_ce←0; all payload outputs ←0.
  - d_i_stall=1: all outputs hold.
  - d_i_ce=0: d_o_ce←0; all payload outputs ←0.
  - Otherwise: d_o_ce←1; decoded payload registered.
- Immediate:
  - Zero-extend instr[15:0] for opcodes 0x0C/0x0D/0x0E (ANDI/ORI/XORI).
  - LUI (0x0F): {instr[15:0], 16'h0}.
  - All other opcodes: sign-extend.
- Destination:
  - opcode 0x00 → rd = instr[15:11].
  - JAL (0x03) → 31.
  - Otherwise → rt.
- d_o_reg_write = 1 for:
  - opcode 0x00 with funct≠0x08 (JR);
  - opcodes 0x03, 0x08–0x0F, 0x20, 0x21, 0x23, 0x24, 0x25.
  - Forced to 0 when the destination resolves to 0.
- Supported opcodes: 0x00, 0x02–0x0F, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B.
  - Any other opcode sets d_o_illegal=1 and d_o_reg_write=0.
  - d_o_ce is still 1 and the fields are still presented.

## Timing
- Reset: every output 0 and every register-file entry 0. d_o_ready follows ~d_i_stall combinationally.
- Latency 1 cycle: inputs sampled at edge N appear at edge N with d_o_ce=1 and stay until the next edge.
- Back-to-back: a new instruction every cycle with no bubble while d_i_stall=0.
- Stall: an instruction presented while d_i_stall=1 is not captured. Upstream must re-present it; d_o_ready signals this.
- Flush and stall together: flush wins, so d_o_ce←0.
- Reset asserted mid-operation: outputs and register file clear immediately (asynchronous). The first capture is on the first edge after deassertion.
- Writeback and decode of the same register at the same edge: the bypass supplies the new data. The stored value updates at that same edge.

## Test plan
- Reset, then write 0x0000_1234 to r5 via writeback; next cycle decode ADD r3,r5,r5 (0x00A51820) → d_o_ce=1, rs_data=rt_data=0x1234, rd_addr=3, reg_write=1.
- Same-edge bypass: d_i_wb_we=1 writing r7=0xDEADBEEF while decoding ORI r2,r7,0x8001 (0x34E28001) → rs_data=0xDEADBEEF, imm=0x0000_8001, rd_addr=2.
- ADDI r4,r0,-1 (0x2004FFFF) → imm=0xFFFF_FFFF, rs_data=0. A write of 0x55 to r0 leaves r0 reading 0.
- JAL 0x0100000 (0x0C100000) → rd_addr=31, reg_write=1, jaddr=0x0100000. SW (0xAC..) → reg_write=0. Opcode 0x3F → illegal=1, reg_write=0, d_o_ce=1.
- Stall held for 3 cycles mid-stream → outputs frozen and d_o_ready=0. Then flush together with stall → d_o_ce=0 and payload 0 on the next edge.
- Deassert d_i_ce for one cycle between two valid instructions → d_o_ce shows 1,0,1. Async reset pulse mid-stream → d_o_ce=0 immediately and earlier register writes read back as 0.
